// File: rtl/ripple_borrow_subtractor_seq.sv
// Multi-cycle ripple-borrow subtractor with valid/ready handshakes on both sides.
// Resolves SLICE bits per clock (LSB slice first) and carries the borrow between
// cycles in a flop. Result layout is {borrow_out, difference}, matching the
// adder family's {carry, sum}.
// Optional feature: define SUB_SIGNED_OVF_EN to add the o_overflow output
// (two's-complement overflow of the subtraction, registered with o_result).
module ripple_borrow_subtractor_seq #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned SLICE = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int unsigned NSLICES = WIDTH / SLICE;
  localparam int unsigned CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICES - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [CNT_W-1:0] count;
  logic             ready;
  logic             valid;
  logic [WIDTH:0]   result;
`ifdef SUB_SIGNED_OVF_EN
  logic             overflow;
`endif

  int unsigned      base;
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_sum;
  logic             borrow_next;
  logic [WIDTH-1:0] diff_next;

  // One slice of a + ~b + !borrow_in; the carry out is the inverted borrow.
  always_comb begin
    base        = 32'(count) * SLICE;
    a_slice     = op_a[base +: SLICE];
    b_slice     = op_b[base +: SLICE];
    slice_sum   = {1'b0, a_slice} + {1'b0, ~b_slice} + {{SLICE{1'b0}}, ~borrow};
    borrow_next = ~slice_sum[SLICE];
    diff_next   = diff;
    diff_next[base +: SLICE] = slice_sum[SLICE-1:0];
  end

  // Handshake FSM and datapath state; result registers load only on the final slice.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= StIdle;
      op_a     <= '0;
      op_b     <= '0;
      diff     <= '0;
      borrow   <= 1'b0;
      count    <= '0;
      ready    <= 1'b1;
      valid    <= 1'b0;
      result   <= '0;
`ifdef SUB_SIGNED_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (i_valid) begin
            op_a   <= i_sub_term1;
            op_b   <= i_sub_term2;
            diff   <= '0;
            borrow <= 1'b0;
            count  <= '0;
            ready  <= 1'b0;
            state  <= StCalc;
          end
        end
        StCalc: begin
          diff   <= diff_next;
          borrow <= borrow_next;
          if (count == LAST_SLICE) begin
            result <= {borrow_next, diff_next};
`ifdef SUB_SIGNED_OVF_EN
            overflow <= (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                        (diff_next[WIDTH-1] != op_a[WIDTH-1]);
`endif
            valid  <= 1'b1;
            state  <= StDone;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        StDone: begin
          if (i_ready) begin
            valid <= 1'b0;
            ready <= 1'b1;
            state <= StIdle;
          end
        end
        default: begin
          valid <= 1'b0;
          ready <= 1'b1;
          state <= StIdle;
        end
      endcase
    end
  end

  assign o_ready  = ready;
  assign o_valid  = valid;
  assign o_result = result;
`ifdef SUB_SIGNED_OVF_EN
  assign o_overflow = overflow;
`endif

endmodule

// File: tb/tb_ripple_borrow_subtractor_seq.sv
// Bench for ripple_borrow_subtractor_seq: four instances (SLICE 1, 3, 4, 12) share
// the inputs; directed checks use the SLICE=4 instance, the random phase checks all
// four against plain-arithmetic reference values.
module tb_ripple_borrow_subtractor_seq;

  localparam int W    = 12;
  localparam int MAIN = 2;
  localparam int NRND = 2000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] term1;
  logic [W-1:0] term2;
  logic         rdy [4];
  logic         vld [4];
  logic [W:0]   res [4];
`ifdef SUB_SIGNED_OVF_EN
  logic         ovf [4];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ripple_borrow_subtractor_seq #(.WIDTH(W), .SLICE(1)) u_s1 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy[0]),
    .i_sub_term1(term1), .i_sub_term2(term2), .o_valid(vld[0]),
    .i_ready(out_ready), .o_result(res[0])
`ifdef SUB_SIGNED_OVF_EN
    , .o_overflow(ovf[0])
`endif
  );
  ripple_borrow_subtractor_seq #(.WIDTH(W), .SLICE(3)) u_s3 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy[1]),
    .i_sub_term1(term1), .i_sub_term2(term2), .o_valid(vld[1]),
    .i_ready(out_ready), .o_result(res[1])
`ifdef SUB_SIGNED_OVF_EN
    , .o_overflow(ovf[1])
`endif
  );
  ripple_borrow_subtractor_seq #(.WIDTH(W), .SLICE(4)) u_s4 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy[2]),
    .i_sub_term1(term1), .i_sub_term2(term2), .o_valid(vld[2]),
    .i_ready(out_ready), .o_result(res[2])
`ifdef SUB_SIGNED_OVF_EN
    , .o_overflow(ovf[2])
`endif
  );
  ripple_borrow_subtractor_seq #(.WIDTH(W), .SLICE(12)) u_s12 (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy[3]),
    .i_sub_term1(term1), .i_sub_term2(term2), .o_valid(vld[3]),
    .i_ready(out_ready), .o_result(res[3])
`ifdef SUB_SIGNED_OVF_EN
    , .o_overflow(ovf[3])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: unsigned 13-bit difference.
  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d;
  endfunction

  // Reference model: signed difference outside the 12-bit two's-complement range.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    int d;
    sa = a[W-1] ? int'(a) - 4096 : int'(a);
    sb = b[W-1] ? int'(b) - 4096 : int'(b);
    d  = sa - sb;
    return (d > 2047) || (d < -2048);
  endfunction

  task automatic wait_main_ready();
    int n = 0;
    while (!rdy[MAIN] && n < 40) begin
      tick();
      n++;
    end
    if (!rdy[MAIN]) check("timeout_ready", 32'(rdy[MAIN]), 1);
  endtask

  task automatic wait_main_valid(output int n);
    n = 0;
    while (!vld[MAIN] && n < 40) begin
      tick();
      n++;
    end
    if (!vld[MAIN]) check("timeout_valid", 32'(vld[MAIN]), 1);
  endtask

  // Presents one operand pair to the SLICE=4 instance for exactly one accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_main_ready();
    term1    = a;
    term2    = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int          lat;
    int          n;
    logic [W:0]  r1;
    logic [W:0]  r2;
    bit          done [4];
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst       = 1'b1;
    in_valid  = 1'b1;  // valid during reset must not be accepted
    out_ready = 1'b1;
    term1     = 12'h321;
    term2     = 12'h123;
    tick();
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_ready", 32'(rdy[MAIN]), 1);
    check("rst_valid", 32'(vld[MAIN]), 0);
    check("rst_result", 32'(res[MAIN]), 0);
`ifdef SUB_SIGNED_OVF_EN
    check("rst_ovf", 32'(ovf[MAIN]), 0);
`endif
    tick();
    check("rst_no_accept", 32'(rdy[MAIN]), 1);

    // 1: 0x800 - 0x001, latency from the accept edge.
    send(12'h800, 12'h001);
    check("t1_busy", 32'(rdy[MAIN]), 0);
    wait_main_valid(lat);
    check("t1_latency", 32'(lat), 3);
    check("t1_result", 32'(res[MAIN]), 32'h07FF);
`ifdef SUB_SIGNED_OVF_EN
    check("t1_ovf", 32'(ovf[MAIN]), 1);
`endif

    // 2: 0x001 - 0x002 borrows out.
    send(12'h001, 12'h002);
    wait_main_valid(lat);
    check("t2_result", 32'(res[MAIN]), 32'h1FFF);
`ifdef SUB_SIGNED_OVF_EN
    check("t2_ovf", 32'(ovf[MAIN]), 0);
`endif

    // 3: back-to-back with valid held high; accepts must be 5 cycles apart.
    wait_main_ready();
    term1    = 12'h000;
    term2    = 12'h000;
    in_valid = 1'b1;
    tick();
    term1 = 12'hFFF;
    term2 = 12'hFFF;
    n  = 0;
    r1 = '1;
    while (!rdy[MAIN] && n < 20) begin
      if (vld[MAIN]) r1 = res[MAIN];
      tick();
      n++;
    end
    tick();
    n++;
    in_valid = 1'b0;
    check("t3_spacing", 32'(n), 5);
    check("t3_result_a", 32'(r1), 0);
    wait_main_valid(lat);
    r2 = res[MAIN];
    check("t3_result_b", 32'(r2), 0);

    // 4: backpressure holds result, valid high and ready low.
    tick();
    out_ready = 1'b0;
    send(12'h5A5, 12'h0A5);
    wait_main_valid(lat);
    for (int i = 0; i < 6; i++) begin
      check("t4_hold_result", 32'(res[MAIN]), 32'h0500);
      check("t4_hold_valid", 32'(vld[MAIN]), 1);
      check("t4_hold_ready", 32'(rdy[MAIN]), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("t4_idle_ready", 32'(rdy[MAIN]), 1);
    check("t4_idle_valid", 32'(vld[MAIN]), 0);

    // 5: reset in the second CALC cycle discards the operation.
    send(12'h123, 12'h456);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", 32'(vld[MAIN]), 0);
    check("t5_result", 32'(res[MAIN]), 0);
    check("t5_ready", 32'(rdy[MAIN]), 1);
    r1 = '0;
    for (int i = 0; i < 8; i++) begin
      if (vld[MAIN]) r1 = 13'h1;
      tick();
    end
    check("t5_no_stale", 32'(r1), 0);

    // 6: random pairs to all four slice widths in lockstep.
    for (int t = 0; t < NRND; t++) begin
      n = 0;
      while (!(rdy[0] && rdy[1] && rdy[2] && rdy[3]) && n < 40) begin
        tick();
        n++;
      end
      if (n >= 40) check("timeout_all_ready", 0, 1);
      a        = W'($urandom);
      b        = W'($urandom);
      if (t < 4) begin  // seed corners: equal, max-min, min-max, signed extremes
        a = (t == 1) ? 12'hFFF : (t == 3) ? 12'h7FF : 12'h000;
        b = (t == 2) ? 12'hFFF : (t == 3) ? 12'h800 : 12'h000;
      end
      term1    = a;
      term2    = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) done[k] = 1'b0;
      n = 0;
      while (!(done[0] && done[1] && done[2] && done[3]) && n < 30) begin
        for (int k = 0; k < 4; k++) begin
          if (vld[k] && !done[k]) begin
            check($sformatf("rnd_result_s%0d", k), 32'(res[k]), 32'(ref_result(a, b)));
`ifdef SUB_SIGNED_OVF_EN
            check($sformatf("rnd_ovf_s%0d", k), 32'(ovf[k]), 32'(ref_ovf(a, b)));
`endif
            done[k] = 1'b1;
          end
        end
        tick();
        n++;
      end
      if (n >= 30) check("timeout_rnd_valid", 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
